// File: rtl/wb_unit_if.sv
// wb_unit_if: bundles the pipeline result, late-result, register-file write
// and hazard-query signals of the write-back unit.
interface wb_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              in_valid;
    logic              in_wen;
    logic [ADDR_W-1:0] in_dest;
    logic              in_mem_sel;
    logic [DATA_W-1:0] in_alu_data;
    logic [DATA_W-1:0] in_mem_data;
    logic              lr_valid;
    logic [ADDR_W-1:0] lr_dest;
    logic [DATA_W-1:0] lr_data;
    logic              lr_ready;
    logic              stall_req;
    logic              reg_write_en;
    logic [ADDR_W-1:0] reg_write_dest;
    logic [DATA_W-1:0] reg_write_data;
    logic [ADDR_W-1:0] wb_op_dest;
    logic [ADDR_W-1:0] haz_addr;
    logic              haz_pending;

    modport master (
        output in_valid, in_wen, in_dest, in_mem_sel, in_alu_data, in_mem_data,
        output lr_valid, lr_dest, lr_data, haz_addr,
        input  lr_ready, stall_req, reg_write_en, reg_write_dest, reg_write_data,
        input  wb_op_dest, haz_pending
    );

    modport slave (
        input  in_valid, in_wen, in_dest, in_mem_sel, in_alu_data, in_mem_data,
        input  lr_valid, lr_dest, lr_data, haz_addr,
        output lr_ready, stall_req, reg_write_en, reg_write_dest, reg_write_data,
        output wb_op_dest, haz_pending
    );
endinterface

// File: rtl/wb_unit.sv
// wb_unit: merges in-order pipeline results and buffered late results onto a
// single registered register-file write port, with WAW squashing of stale
// late results and a hazard query over pending FIFO entries.
module wb_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input logic      clk,
    input logic      rst,
    wb_unit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_valid [DEPTH];
    logic [ADDR_W-1:0] fifo_dest  [DEPTH];
    logic [DATA_W-1:0] fifo_data  [DEPTH];

    logic              full;
    logic              empty;
    logic              pipe_live;
    logic              enq;
    logic              enq_valid;
    logic              deq;
    logic [DATA_W-1:0] pipe_data;
    logic              haz_hit;

    logic              wen_q;
    logic [ADDR_W-1:0] wdest_q;
    logic [DATA_W-1:0] wdata_q;

    // Arbitration: a full FIFO forces a drain, else pipeline wins, else drain.
    always_comb begin
        full      = (count == CNT_W'(DEPTH));
        empty     = (count == '0);
        pipe_live = bus.in_valid & bus.in_wen & (bus.in_dest != '0) & ~full;
        enq       = bus.lr_valid & ~full & (bus.lr_dest != '0);
        // A same-cycle pipeline write to the same register makes the late result stale.
        enq_valid = ~(pipe_live && (bus.in_dest == bus.lr_dest));
        deq       = full | (~pipe_live & ~empty);
        pipe_data = bus.in_mem_sel ? bus.in_mem_data : bus.in_alu_data;
    end

    // Hazard query over valid FIFO entries only.
    always_comb begin
        haz_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i] && (fifo_dest[i] == bus.haz_addr)) begin
                haz_hit = 1'b1;
            end
        end
    end

    assign bus.lr_ready       = ~full;
    assign bus.stall_req      = full;
    assign bus.haz_pending    = haz_hit;
    assign bus.reg_write_en   = wen_q;
    assign bus.reg_write_dest = wdest_q;
    assign bus.reg_write_data = wdata_q;
    assign bus.wb_op_dest     = wen_q ? wdest_q : '0;

    // Late-result FIFO: squash, pop, push and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_valid[i] <= 1'b0;
                fifo_dest[i]  <= '0;
                fifo_data[i]  <= '0;
            end
        end else begin
            // Squash first so a push in the same cycle sets its own valid bit.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (pipe_live && (fifo_dest[i] == bus.in_dest)) begin
                    fifo_valid[i] <= 1'b0;
                end
            end
            if (deq) begin
                fifo_valid[rd_ptr] <= 1'b0;
                rd_ptr             <= rd_ptr + PTR_W'(1);
            end
            if (enq) begin
                fifo_valid[wr_ptr] <= enq_valid;
                fifo_dest[wr_ptr]  <= bus.lr_dest;
                fifo_data[wr_ptr]  <= bus.lr_data;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Registered write port; dest/data hold when no write is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q   <= 1'b0;
            wdest_q <= '0;
            wdata_q <= '0;
        end else if (pipe_live) begin
            wen_q   <= 1'b1;
            wdest_q <= bus.in_dest;
            wdata_q <= pipe_data;
        end else if (deq) begin
            wen_q <= fifo_valid[rd_ptr];
            if (fifo_valid[rd_ptr]) begin
                wdest_q <= fifo_dest[rd_ptr];
                wdata_q <= fifo_data[rd_ptr];
            end
        end else begin
            wen_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: scenario tasks with inline checks plus a scoreboard of expected
// register-file writes consumed by a write-port monitor.
module tb_wb_unit;
    typedef struct packed {
        logic [2:0]  dest;
        logic [15:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    wr_t  exp_q[$];
    wr_t  e;

    wb_unit_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    wb_unit #(.DATA_W(16), .ADDR_W(3), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    // Every issued write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.reg_write_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got dest=%0d data=%h, expected no write",
                         bus.reg_write_dest, bus.reg_write_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.reg_write_dest, bus.reg_write_data} !== {e.dest, e.data}) begin
                    errors++;
                    $display("FAIL sb_write got dest=%0d data=%h, expected dest=%0d data=%h",
                             bus.reg_write_dest, bus.reg_write_data, e.dest, e.data);
                end
                checks++;
                if (bus.wb_op_dest !== e.dest) begin
                    errors++;
                    $display("FAIL sb_wb_op_dest got %0d, expected %0d", bus.wb_op_dest, e.dest);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.in_wen      = 1'b0;
        bus.in_dest     = '0;
        bus.in_mem_sel  = 1'b0;
        bus.in_alu_data = '0;
        bus.in_mem_data = '0;
        bus.lr_valid    = 1'b0;
        bus.lr_dest     = '0;
        bus.lr_data     = '0;
    endtask

    task automatic drive_pipe(input logic [2:0] dest, input logic [15:0] data);
        bus.in_valid    = 1'b1;
        bus.in_wen      = 1'b1;
        bus.in_dest     = dest;
        bus.in_mem_sel  = 1'b0;
        bus.in_alu_data = data;
        bus.in_mem_data = ~data;
    endtask

    task automatic drive_late(input logic [2:0] dest, input logic [15:0] data);
        bus.lr_valid = 1'b1;
        bus.lr_dest  = dest;
        bus.lr_data  = data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.haz_addr = 3'd0;
        cyc();
        cyc();
        checks++;
        if ({bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data} !== 20'd0) begin
            errors++;
            $display("FAIL reset_write_port got en=%b dest=%0d data=%h, expected 0/0/0000",
                     bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data);
        end
        checks++;
        if ({bus.lr_ready, bus.stall_req, bus.wb_op_dest, bus.haz_pending} !== 6'b10_000_0) begin
            errors++;
            $display("FAIL reset_comb got lr_ready=%b stall=%b wb_op_dest=%0d haz=%b, expected 1/0/0/0",
                     bus.lr_ready, bus.stall_req, bus.wb_op_dest, bus.haz_pending);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (bus.reg_write_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_en got %b, expected 0", bus.reg_write_en);
        end
    endtask

    task automatic test_pipeline();
        cyc();
        drive_pipe(3'd5, 16'h1234);
        bus.in_mem_data = 16'hBEEF;
        exp_q.push_back(wr_t'{dest: 3'd5, data: 16'h1234});
        cyc();
        bus.in_mem_sel = 1'b1;
        exp_q.push_back(wr_t'{dest: 3'd5, data: 16'hBEEF});
        #1;
        checks++;
        if ({bus.reg_write_en, bus.wb_op_dest, bus.reg_write_data} !== {1'b1, 3'd5, 16'h1234}) begin
            errors++;
            $display("FAIL pipe_alu got en=%b wb_op_dest=%0d data=%h, expected 1/5/1234",
                     bus.reg_write_en, bus.wb_op_dest, bus.reg_write_data);
        end
        cyc();
        idle_inputs();
        #1;
        checks++;
        if (bus.reg_write_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL pipe_mem got data=%h, expected beef", bus.reg_write_data);
        end
        cyc();
        checks++;
        if ({bus.reg_write_en, bus.wb_op_dest, bus.reg_write_dest, bus.reg_write_data}
            !== {1'b0, 3'd0, 3'd5, 16'hBEEF}) begin
            errors++;
            $display("FAIL pipe_hold got en=%b wb_op_dest=%0d dest=%0d data=%h, expected 0/0/5/beef",
                     bus.reg_write_en, bus.wb_op_dest, bus.reg_write_dest, bus.reg_write_data);
        end
    endtask

    task automatic test_late();
        cyc();
        drive_late(3'd3, 16'h00A5);
        bus.haz_addr = 3'd3;
        exp_q.push_back(wr_t'{dest: 3'd3, data: 16'h00A5});
        #1;
        checks++;
        if ({bus.lr_ready, bus.haz_pending} !== 2'b10) begin
            errors++;
            $display("FAIL late_accept got lr_ready=%b haz=%b, expected 1/0",
                     bus.lr_ready, bus.haz_pending);
        end
        cyc();
        idle_inputs();
        #1;
        checks++;
        if ({bus.haz_pending, bus.reg_write_en} !== 2'b10) begin
            errors++;
            $display("FAIL late_pending got haz=%b en=%b, expected 1/0",
                     bus.haz_pending, bus.reg_write_en);
        end
        cyc();
        checks++;
        if ({bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data, bus.haz_pending}
            !== {1'b1, 3'd3, 16'h00A5, 1'b0}) begin
            errors++;
            $display("FAIL late_write got en=%b dest=%0d data=%h haz=%b, expected 1/3/00a5/0",
                     bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data, bus.haz_pending);
        end
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL late_drained got %0d outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        int  pidx   [12] = '{0, 1, 2, 3, 4, 4, 5, -1, -1, -1, -1, -1};
        logic [2:0] ldest [4] = '{3'd2, 3'd3, 3'd4, 3'd6};
        for (int k = 0; k < 4; k++)
            exp_q.push_back(wr_t'{dest: 3'd1, data: 16'h1000 + 16'(k)});
        exp_q.push_back(wr_t'{dest: 3'd2, data: 16'h0A02});
        exp_q.push_back(wr_t'{dest: 3'd1, data: 16'h1004});
        exp_q.push_back(wr_t'{dest: 3'd1, data: 16'h1005});
        exp_q.push_back(wr_t'{dest: 3'd3, data: 16'h0A03});
        exp_q.push_back(wr_t'{dest: 3'd4, data: 16'h0A04});
        exp_q.push_back(wr_t'{dest: 3'd6, data: 16'h0A06});
        for (int c = 0; c < 12; c++) begin
            cyc();
            idle_inputs();
            if (pidx[c] >= 0) drive_pipe(3'd1, 16'h1000 + 16'(pidx[c]));
            if (c < 4) drive_late(ldest[c], 16'h0A00 + 16'(ldest[c]));
            #1;
            checks++;
            if ({bus.stall_req, bus.lr_ready} !== {(c == 4), (c != 4)}) begin
                errors++;
                $display("FAIL stall_cycle%0d got stall=%b lr_ready=%b, expected %b/%b",
                         c, bus.stall_req, bus.lr_ready, (c == 4), (c != 4));
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drained got %0d outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_squash();
        cyc();
        drive_late(3'd4, 16'h4444);
        bus.haz_addr = 3'd4;
        cyc();
        idle_inputs();
        drive_pipe(3'd4, 16'h7777);
        exp_q.push_back(wr_t'{dest: 3'd4, data: 16'h7777});
        #1;
        checks++;
        if (bus.haz_pending !== 1'b1) begin
            errors++;
            $display("FAIL squash_pending got haz=%b, expected 1", bus.haz_pending);
        end
        cyc();
        idle_inputs();
        #1;
        checks++;
        if ({bus.reg_write_en, bus.reg_write_data, bus.haz_pending} !== {1'b1, 16'h7777, 1'b0}) begin
            errors++;
            $display("FAIL squash_write got en=%b data=%h haz=%b, expected 1/7777/0",
                     bus.reg_write_en, bus.reg_write_data, bus.haz_pending);
        end
        cyc();
        checks++;
        if ({bus.reg_write_en, bus.wb_op_dest, bus.reg_write_data} !== {1'b0, 3'd0, 16'h7777}) begin
            errors++;
            $display("FAIL squash_pop got en=%b wb_op_dest=%0d data=%h, expected 0/0/7777",
                     bus.reg_write_en, bus.wb_op_dest, bus.reg_write_data);
        end
        cyc();
        checks++;
        if (exp_q.size() != 0 || bus.reg_write_en !== 1'b0) begin
            errors++;
            $display("FAIL squash_end got %0d outstanding en=%b, expected 0/0",
                     exp_q.size(), bus.reg_write_en);
        end
    endtask

    task automatic test_same_cycle();
        cyc();
        drive_late(3'd2, 16'h2222);
        drive_pipe(3'd2, 16'h5555);
        bus.haz_addr = 3'd2;
        exp_q.push_back(wr_t'{dest: 3'd2, data: 16'h5555});
        cyc();
        idle_inputs();
        #1;
        checks++;
        if ({bus.haz_pending, bus.reg_write_en, bus.reg_write_data} !== {1'b0, 1'b1, 16'h5555}) begin
            errors++;
            $display("FAIL same_cycle got haz=%b en=%b data=%h, expected 0/1/5555",
                     bus.haz_pending, bus.reg_write_en, bus.reg_write_data);
        end
        cyc();
        checks++;
        if (bus.reg_write_en !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_pop got en=%b, expected 0", bus.reg_write_en);
        end
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL same_cycle_drained got %0d outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_zero_dest();
        cyc();
        drive_late(3'd0, 16'hDEAD);
        drive_pipe(3'd0, 16'h9999);
        #1;
        checks++;
        if (bus.lr_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_lr_ready got %b, expected 1", bus.lr_ready);
        end
        for (int c = 0; c < 3; c++) begin
            cyc();
            idle_inputs();
            #1;
            checks++;
            if ({bus.reg_write_en, bus.wb_op_dest} !== 4'd0) begin
                errors++;
                $display("FAIL zero_no_write%0d got en=%b wb_op_dest=%0d, expected 0/0",
                         c, bus.reg_write_en, bus.wb_op_dest);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 5; c++) begin
            cyc();
            idle_inputs();
            drive_pipe(3'd7, 16'h7000 + 16'(c));
            if (c < 4) exp_q.push_back(wr_t'{dest: 3'd7, data: 16'h7000 + 16'(c)});
            if (c < 3) drive_late(3'(c + 1), 16'h0B00 + 16'(c));
        end
        bus.haz_addr = 3'd1;
        #1;
        checks++;
        if (bus.haz_pending !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pending got haz=%b, expected 1", bus.haz_pending);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data, bus.wb_op_dest,
             bus.haz_pending, bus.stall_req, bus.lr_ready} !== {1'b0, 3'd0, 16'h0, 3'd0, 3'b001}) begin
            errors++;
            $display("FAIL rst_mid_async got en=%b dest=%0d data=%h wb=%0d haz=%b stall=%b rdy=%b, expected 0/0/0/0/0/0/1",
                     bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data, bus.wb_op_dest,
                     bus.haz_pending, bus.stall_req, bus.lr_ready);
        end
        idle_inputs();
        cyc();
        cyc();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            checks++;
            if (bus.reg_write_en !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_release%0d got en=%b, expected 0", c, bus.reg_write_en);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_drained got %0d outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_pipeline();
        test_late();
        test_stall();
        test_squash();
        test_same_cycle();
        test_zero_dest();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
